// File: rtl/pwm_beeper.sv
// pwm_beeper: programmable-period/duty tone generator gated by an on/off
// cadence. Plays a fixed number of beeps (or runs until stopped) and
// reports busy/done to the controlling logic. Sits in front of the buzzer pin.
module pwm_beeper #(
    parameter int   CLK_HZ   = 50_000_000,
    parameter int   TICK_HZ  = 1000,
    parameter int   PW       = 16,
    parameter int   TW       = 12,
    parameter int   CW       = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] period,
    input  logic [PW-1:0] duty,
    input  logic [TW-1:0] on_ticks,
    input  logic [TW-1:0] off_ticks,
    input  logic [CW-1:0] beeps,
    output logic          pwmout,
    output logic          busy,
    output logic          done
);

    // Cycles per cadence tick; a divider below 1 degenerates to one cycle per tick.
    localparam int TICK_DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]       r_state;
    logic [PRE_W-1:0] r_pre;
    logic [TW-1:0]    r_tick;
    logic [PW-1:0]    r_tone;
    logic [CW-1:0]    r_beep_cnt;
    logic [PW-1:0]    r_period;
    logic [PW-1:0]    r_duty;
    logic [TW-1:0]    r_on_ticks;
    logic [TW-1:0]    r_off_ticks;
    logic [CW-1:0]    r_beeps;
    logic             r_pwm;
    logic             r_done;

    logic             w_accept;
    logic             w_active;
    logic             w_abort;
    logic             w_tick_end;
    logic [TW-1:0]    w_phase_len;
    logic             w_phase_end;
    logic [CW-1:0]    w_beep_next;
    logic             w_last_beep;
    logic             w_tone_req;

    // start and stop together in IDLE is deliberately not an accept.
    assign w_accept    = (r_state == S_IDLE) && start && !stop;
    assign w_active    = (r_state == S_ON) || (r_state == S_OFF);
    assign w_abort     = w_active && stop;
    assign w_tick_end  = (r_pre == PRE_LAST);
    assign w_phase_len = (r_state == S_ON) ? r_on_ticks : r_off_ticks;
    // Tick counter runs 0..len-1; the phase ends on the last cycle of the last tick.
    assign w_phase_end = w_active && w_tick_end && (r_tick == w_phase_len - TW'(1));
    assign w_beep_next = r_beep_cnt + CW'(1);
    assign w_last_beep = (r_beeps != '0) && (w_beep_next == r_beeps);
    assign w_tone_req  = (r_state == S_ON) && (r_tone < r_duty);

    assign busy   = w_active;
    assign done   = r_done;
    assign pwmout = r_pwm;

    // Latch the run configuration on accept, substituting the degenerate values.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period    <= '0;
            r_duty      <= '0;
            r_on_ticks  <= '0;
            r_off_ticks <= '0;
            r_beeps     <= '0;
        end else if (w_accept) begin
            r_period    <= (period < PW'(2)) ? PW'(2) : period;
            r_duty      <= duty;
            r_on_ticks  <= (on_ticks  == '0) ? TW'(1) : on_ticks;
            r_off_ticks <= (off_ticks == '0) ? TW'(1) : off_ticks;
            r_beeps     <= beeps;
        end
    end

    // State machine and the one-cycle done pulse on every return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_ON;
                    end
                end
                S_ON: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_phase_end) begin
                        if (w_last_beep) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_OFF;
                        end
                    end
                end
                S_OFF: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_phase_end) begin
                        r_state <= S_ON;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Phase timer: prescaler and tick counter, cleared on every phase entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre  <= '0;
            r_tick <= '0;
        end else if (!w_active || w_phase_end || w_abort) begin
            r_pre  <= '0;
            r_tick <= '0;
        end else if (w_tick_end) begin
            r_pre  <= '0;
            r_tick <= r_tick + TW'(1);
        end else begin
            r_pre  <= r_pre + PRE_W'(1);
        end
    end

    // Tone counter: wraps at period-1 while ON, held at 0 otherwise so each beep starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tone <= '0;
        end else if ((r_state != S_ON) || w_phase_end || w_abort) begin
            r_tone <= '0;
        end else if (r_tone == r_period - PW'(1)) begin
            r_tone <= '0;
        end else begin
            r_tone <= r_tone + PW'(1);
        end
    end

    // Beep counter: counts completed ON phases; frozen in continuous mode so it cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beep_cnt <= '0;
        end else if (w_accept) begin
            r_beep_cnt <= '0;
        end else if ((r_state == S_ON) && !stop && w_phase_end && (r_beeps != '0)) begin
            r_beep_cnt <= w_beep_next;
        end
    end

    // Registered PWM pin driven from the current state and tone count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= IDLE_LVL;
        end else begin
            r_pwm <= w_tone_req ? ~IDLE_LVL : IDLE_LVL;
        end
    end

endmodule

// File: tb/tb_pwm_beeper.sv
// Self-checking bench for pwm_beeper. Expected per-cycle (pwmout, busy, done)
// triples are pushed to a scoreboard queue when a run is launched and popped
// and compared at each falling edge while the run plays out.
module tb_pwm_beeper;

    localparam int TICK_DIV = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period = 16'd4;
    logic [15:0] duty = 16'd1;
    logic [11:0] on_ticks = 12'd2;
    logic [11:0] off_ticks = 12'd1;
    logic [7:0]  beeps = 8'd2;
    logic        pwmout;
    logic        busy;
    logic        done;

    typedef struct {
        logic pwm;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pwm_beeper #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .PW      (16),
        .TW      (12),
        .CW      (8),
        .IDLE_LVL(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .duty     (duty),
        .on_ticks (on_ticks),
        .off_ticks(off_ticks),
        .beeps    (beeps),
        .pwmout   (pwmout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Reference schedule: cycle p of a run is ON when (p mod (t_on+t_off)) < t_on;
    // inside ON the tone position is that offset mod period. Active level is 0.
    function automatic logic exp_pwm(input int p, input int len, input int t_on,
                                     input int t_off, input int per, input int dut_v);
        int q;
        if (p < 0 || p >= len) return 1'b1;
        q = p % (t_on + t_off);
        if (q < t_on && (q % per) < dut_v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_idle(input int n);
        exp_t e;
        e.pwm  = 1'b1;
        e.busy = 1'b0;
        e.done = 1'b0;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic pop_check(input string name, input int j);
        exp_t e;
        if (sb_q.size() == 0) begin
            check($sformatf("%s[%0d].sb_underflow", name, j), 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("%s[%0d].pwmout", name, j), 32'(pwmout), 32'(e.pwm));
            check($sformatf("%s[%0d].busy", name, j), 32'(busy), 32'(e.busy));
            check($sformatf("%s[%0d].done", name, j), 32'(done), 32'(e.done));
        end
    endtask

    // Launch one run. stop_at>0 asserts stop so the edge that samples it is the
    // stop_at-th edge after the accepting edge; both=1 drives start and stop
    // together; poke=1 changes period/duty and re-pulses start while busy.
    task automatic run_case(input string name, input int per, input int dut_v,
                            input int on_t, input int off_t, input int nb,
                            input int stop_at, input bit both, input bit poke);
        int   p_eff, on_eff, off_eff, t_on, t_off, len, n_samp;
        exp_t e;
        p_eff   = (per < 2) ? 2 : per;
        on_eff  = (on_t == 0) ? 1 : on_t;
        off_eff = (off_t == 0) ? 1 : off_t;
        t_on    = on_eff * TICK_DIV;
        t_off   = off_eff * TICK_DIV;
        if (both)         len = 0;
        else if (nb == 0) len = stop_at;
        else              len = nb * t_on + (nb - 1) * t_off;
        if (!both && stop_at > 0 && stop_at < len) len = stop_at;
        n_samp = len + 4;
        if (n_samp < 6) n_samp = 6;
        for (int j = 0; j < n_samp; j++) begin
            e.busy = (j < len);
            e.done = (len > 0) && (j == len);
            e.pwm  = exp_pwm(j - 1, len, t_on, t_off, p_eff, dut_v);
            sb_q.push_back(e);
        end

        period    = 16'(per);
        duty      = 16'(dut_v);
        on_ticks  = 12'(on_t);
        off_ticks = 12'(off_t);
        beeps     = 8'(nb);
        start     = 1'b1;
        stop      = both;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int j = 0; j < n_samp; j++) begin
            @(negedge clk);
            pop_check(name, j);
            if (stop_at > 0 && j == stop_at - 1) stop = 1'b1;
            if (stop_at > 0 && j == stop_at)     stop = 1'b0;
            if (poke) begin
                if (j == 15) begin
                    period = 16'd3;
                    duty   = 16'd2;
                end
                if (j == 25) start = 1'b1;
                if (j == 26) start = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        // Reset held: idle outputs.
        repeat (3) @(negedge clk);
        check("reset.pwmout", 32'(pwmout), 32'd1);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);

        // Released with no start: nothing moves for 100 cycles.
        rst = 1'b0;
        push_idle(100);
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            pop_check("post_reset", j);
        end

        run_case("two_beeps",  4, 1, 2, 1, 2, 0,  1'b0, 1'b0);
        run_case("duty_zero",  4, 0, 2, 1, 2, 0,  1'b0, 1'b0);
        run_case("duty_full",  4, 7, 2, 1, 1, 0,  1'b0, 1'b0);
        run_case("cont_stop",  4, 1, 1, 1, 0, 37, 1'b0, 1'b0);
        run_case("start_stop", 4, 1, 2, 1, 2, 0,  1'b1, 1'b0);
        run_case("busy_poke",  4, 1, 2, 1, 2, 0,  1'b0, 1'b1);
        run_case("degenerate", 1, 1, 0, 0, 1, 0,  1'b0, 1'b0);

        // Reset in the middle of ON: outputs drop asynchronously, no done.
        period    = 16'd4;
        duty      = 16'd7;
        on_ticks  = 12'd2;
        off_ticks = 12'd1;
        beeps     = 8'd1;
        for (int j = 0; j < 5; j++) begin
            e.busy = 1'b1;
            e.done = 1'b0;
            e.pwm  = exp_pwm(j - 1, 20, 20, 10, 4, 7);
            sb_q.push_back(e);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            pop_check("rst_mid_on", j);
        end
        #1;
        rst = 1'b1;
        #1;
        check("rst_async.pwmout", 32'(pwmout), 32'd1);
        check("rst_async.busy", 32'(busy), 32'd0);
        check("rst_async.done", 32'(done), 32'd0);
        push_idle(3);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            pop_check("rst_hold", j);
        end
        rst = 1'b0;
        push_idle(5);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            pop_check("rst_release", j);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
